// File: rtl/pll_clk_manager.sv
// Post-PLL clock manager: filters the PLL lock flag, sequences the system reset,
// and generates phase-aligned single-cycle clock-enable strobes in the PLL domain.
module pll_clk_manager #(
  parameter int                   NCH       = 2,
  parameter int                   DIV_W     = 24,
  parameter logic [NCH*DIV_W-1:0] DIVS      = {24'd250000, 24'd25},
  parameter int                   LOCK_FILT = 1024,
  parameter int                   RST_HOLD  = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pll_locked,
  input  logic [NCH-1:0] ch_en,
  output logic           sys_rst,
  output logic           ready,
  output logic [NCH-1:0] ce,
  output logic [7:0]     lock_loss_cnt,
  output logic [1:0]     state
);

  localparam int FW = $clog2(LOCK_FILT + 1);
  localparam int HW = $clog2(RST_HOLD + 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  logic          sync1, sync2;
  logic [FW-1:0] filt_cnt;
  logic          lock_ok;
  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          loss_inc;
  logic          sys_rst_q;
  logic [7:0]    loss_q;
  logic          advance;

  // NOTE: sequential state is written only with non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pll_locked;
      sync2 <= sync1;
    end
  end

  // Any low synchronised sample restarts the filter; saturates once lock is trusted.
  always_ff @(posedge clk) begin
    if (reset || !sync2) begin
      filt_cnt <= '0;
    end else if (!lock_ok) begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign lock_ok = (filt_cnt == FW'(LOCK_FILT));

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    hold_d   = '0;
    loss_inc = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_ok) state_d = HOLD;
      end
      HOLD: begin
        if (!lock_ok) begin
          state_d = WAIT_LOCK;
        end else if (hold_q == HW'(RST_HOLD - 1)) begin
          state_d = RUN;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RUN: begin
        if (!lock_ok) begin
          state_d  = WAIT_LOCK;
          loss_inc = 1'b1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // sys_rst is a flop driven from the next state, so it never glitches on decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= WAIT_LOCK;
      hold_q    <= '0;
      sys_rst_q <= 1'b1;
      loss_q    <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      sys_rst_q <= (state_d != RUN);
      if (loss_inc && (loss_q != 8'hFF)) loss_q <= loss_q + 1'b1;
    end
  end

  assign sys_rst       = sys_rst_q;
  assign ready         = ~sys_rst_q;
  assign state         = state_q;
  assign lock_loss_cnt = loss_q;

  // Counters advance only between two RUN cycles: all start together on entry
  // and are already clear in the first cycle after RUN is left.
  assign advance = (state_q == RUN) && (state_d == RUN);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam logic [DIV_W-1:0] DIV = DIVS[i*DIV_W +: DIV_W];

    logic [DIV_W-1:0] cnt;
    logic             ce_q;
    logic             run_ch;
    logic             at_end;

    assign run_ch = advance && ch_en[i] && (DIV != '0);
    assign at_end = (cnt == DIV - 1'b1);

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt  <= '0;
        ce_q <= 1'b0;
      end else begin
        if (run_ch) cnt <= at_end ? '0 : cnt + 1'b1;
        else        cnt <= '0;
        ce_q <= run_ch && at_end;
      end
    end

    assign ce[i] = ce_q;
  end

endmodule

// File: tb/tb_pll_clk_manager.sv
// Self-checking bench for pll_clk_manager: directed lock/reset scenarios plus random
// lock dropouts and channel enables, compared against a run-length reference model.
module tb_pll_clk_manager;

  localparam int NCH   = 2;
  localparam int DIV_W = 24;
  localparam int LF    = 8;
  localparam int RH    = 4;

  logic           clk;
  logic           reset;
  logic           pll_locked;
  logic [NCH-1:0] ch_en;
  logic           sys_rst;
  logic           ready;
  logic [NCH-1:0] ce;
  logic [7:0]     lock_loss_cnt;
  logic [1:0]     state;

  int checks   = 0;
  int failures = 0;

  pll_clk_manager #(
    .NCH      (NCH),
    .DIV_W    (DIV_W),
    .DIVS     ({24'd5, 24'd1}),
    .LOCK_FILT(LF),
    .RST_HOLD (RH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pll_locked   (pll_locked),
    .ch_en        (ch_en),
    .sys_rst      (sys_rst),
    .ready        (ready),
    .ce           (ce),
    .lock_loss_cnt(lock_loss_cnt),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: lock is trusted after LF consecutive high samples seen two
  // edges late; the system runs once lock has been trusted for RH+1 cycles in a row;
  // a channel strobes whenever its count of consecutive enabled RUN cycles is a
  // multiple of its divisor.
  bit             lk_q[$];
  int             m_hi;
  bit             m_ok;
  int             m_okc;
  int             m_loss;
  int             m_enrun[NCH];
  bit [NCH-1:0]   m_ce;

  function automatic int div_of(input int i);
    return (i == 0) ? 1 : 5;
  endfunction

  function automatic int state_of(input int okc);
    if (okc == 0) return 0;
    if (okc <= RH) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    lk_q.delete();
    m_hi   = 0;
    m_ok   = 1'b0;
    m_okc  = 0;
    m_loss = 0;
    m_ce   = '0;
    for (int i = 0; i < NCH; i++) m_enrun[i] = 0;
  endtask

  task automatic model_edge(input bit lk, input logic [NCH-1:0] en);
    int cur_st, new_st;
    bit d;
    cur_st = state_of(m_okc);
    for (int i = 0; i < NCH; i++)
      m_enrun[i] = (cur_st == 2 && en[i]) ? m_enrun[i] + 1 : 0;
    m_okc  = m_ok ? ((m_okc < RH + 1) ? m_okc + 1 : m_okc) : 0;
    new_st = state_of(m_okc);
    if (cur_st == 2 && new_st == 0 && m_loss < 255) m_loss++;
    lk_q.push_back(lk);
    d = (lk_q.size() >= 3) ? lk_q[lk_q.size() - 3] : 1'b0;
    if (lk_q.size() > 3) void'(lk_q.pop_front());
    m_hi = d ? ((m_hi < LF) ? m_hi + 1 : m_hi) : 0;
    m_ok = (m_hi == LF);
    for (int i = 0; i < NCH; i++)
      m_ce[i] = (new_st == 2) && (div_of(i) != 0) && (m_enrun[i] > 0) &&
                (m_enrun[i] % div_of(i) == 0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after it.
  task automatic step(input bit rst, input bit lk, input logic [NCH-1:0] en);
    int st;
    reset      = rst;
    pll_locked = lk;
    ch_en      = en;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(lk, en);
    #1;
    st = state_of(m_okc);
    check("sys_rst",       32'(sys_rst),       32'(st != 2));
    check("ready",         32'(ready),         32'(st == 2));
    check("state",         32'(state),         32'(st));
    check("ce",            32'(ce),            32'(m_ce));
    check("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_loss));
    @(negedge clk);
  endtask

  task automatic wait_ready(input logic [NCH-1:0] en, output int lat);
    lat = -1;
    for (int j = 0; j < 60; j++) begin
      step(1'b0, 1'b1, en);
      if (ready === 1'b1) begin
        lat = j;
        break;
      end
    end
  endtask

  task automatic drop_and_relock(input logic [NCH-1:0] en, output int rise, output int fall,
                                 output logic [NCH-1:0] ce_at_rise);
    rise       = -1;
    fall       = -1;
    ce_at_rise = 'x;
    step(1'b0, 1'b0, en);
    for (int j = 1; j < 40; j++) begin
      step(1'b0, 1'b1, en);
      if (rise < 0 && sys_rst === 1'b1) begin
        rise       = j;
        ce_at_rise = ce;
      end
      if (rise >= 0 && ready === 1'b1) begin
        fall = j - 1;
        break;
      end
    end
  endtask

  initial begin
    int             lat, rise, fall, first, n0, n1;
    logic [NCH-1:0] ce_r;

    reset      = 1'b1;
    pll_locked = 1'b0;
    ch_en      = '0;
    model_reset();
    @(negedge clk);

    // Reset values
    step(1'b1, 1'b0, 2'b00);
    step(1'b1, 1'b0, 2'b00);
    check("rst_sys_rst", 32'(sys_rst),       32'd1);
    check("rst_ready",   32'(ready),         32'd0);
    check("rst_state",   32'(state),         32'd0);
    check("rst_ce",      32'(ce),            32'd0);
    check("rst_loss",    32'(lock_loss_cnt), 32'd0);

    // 1: lock from the first edge -> sys_rst falls 14 cycles later
    wait_ready(2'b11, lat);
    check("lock_latency", 32'(lat), 32'd14);

    // 2: strobe cadence right after RUN entry
    first = -1; n0 = 0; n1 = 0;
    for (int j = 1; j <= 20; j++) begin
      step(1'b0, 1'b1, 2'b11);
      n0 += int'(ce[0]);
      n1 += int'(ce[1]);
      if (first < 0 && ce[1] === 1'b1) first = j;
    end
    check("ce1_first",  32'(first), 32'd5);
    check("ce0_count",  32'(n0),    32'd20);
    check("ce1_count",  32'(n1),    32'd4);

    // 3: one-cycle dropout at filter count 5 restarts the filter
    step(1'b1, 1'b0, 2'b00);
    for (int j = 0; j < 5; j++) step(1'b0, 1'b1, 2'b11);
    step(1'b0, 1'b0, 2'b11);
    wait_ready(2'b11, lat);
    check("refilter_latency", 32'(lat), 32'd14);

    // 5: ch_en[1] off for 3 cycles mid-period, then on
    for (int j = 0; j < 7; j++) step(1'b0, 1'b1, 2'b11);
    for (int j = 0; j < 3; j++) step(1'b0, 1'b1, 2'b01);
    first = -1;
    for (int j = 1; j <= 10; j++) begin
      step(1'b0, 1'b1, 2'b11);
      if (first < 0 && ce[1] === 1'b1) first = j;
    end
    check("reenable_first", 32'(first), 32'd5);

    // 4: lock loss in RUN
    drop_and_relock(2'b11, rise, fall, ce_r);
    check("loss_rise",    32'(rise),          32'd3);
    check("loss_ce_zero", 32'(ce_r),          32'd0);
    check("relock",       32'(fall),          32'd14);
    check("loss_count1",  32'(lock_loss_cnt), 32'd1);

    // Random lock dropouts and channel enables
    for (int j = 0; j < 400; j++)
      step(1'b0, ($urandom_range(0, 39) != 0), 2'($urandom_range(0, 3)));
    wait_ready(2'($urandom_range(0, 3)), lat);
    check("resync", 32'(lat >= 0), 32'd1);

    // 6: 256 forced losses saturate the counter
    for (int k = 0; k < 256; k++) begin
      drop_and_relock(2'($urandom_range(0, 3)), rise, fall, ce_r);
      check("sat_rise", 32'(rise), 32'd3);
      check("sat_fall", 32'(fall), 32'd14);
    end
    check("loss_saturated",  32'(lock_loss_cnt), 32'd255);
    step(1'b0, 1'b1, 2'b11);
    check("pre_reset_state", 32'(state), 32'd2);
    step(1'b1, 1'b1, 2'b11);
    check("mid_rst_sys_rst", 32'(sys_rst),       32'd1);
    check("mid_rst_ready",   32'(ready),         32'd0);
    check("mid_rst_state",   32'(state),         32'd0);
    check("mid_rst_ce",      32'(ce),            32'd0);
    check("mid_rst_loss",    32'(lock_loss_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
